// File: rtl/imem_fetch_ctrl_pkg.sv
// rtl/imem_fetch_ctrl_pkg.sv - shared types and constants for the instruction-fetch sequencer
package imem_fetch_ctrl_pkg;

  localparam logic [31:0] NOP_INSN = 32'h00000013;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // One prefetch buffer entry: byte PC of the word plus the word itself.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
  } entry_t;

  // Clear the byte-offset bits so every PC is word aligned.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/imem_fetch_ctrl_if.sv
// rtl/imem_fetch_ctrl_if.sv - ROM, redirect and instruction-delivery signals of the fetch sequencer
interface imem_fetch_ctrl_if #(
  parameter int ADDR_BITS = 4
);
  logic [ADDR_BITS-1:0] rom_addr;
  logic [31:0]          rom_data;
  logic                 redirect_valid;
  logic [31:0]          redirect_pc;
  logic                 instr_valid;
  logic [31:0]          instr;
  logic [31:0]          instr_pc;
  logic                 instr_ready;

  modport master (
    output rom_addr, instr_valid, instr, instr_pc,
    input  rom_data, redirect_valid, redirect_pc, instr_ready
  );

  modport slave (
    input  rom_addr, instr_valid, instr, instr_pc,
    output rom_data, redirect_valid, redirect_pc, instr_ready
  );
endinterface

// File: rtl/imem_fetch_ctrl_fifo2.sv
// rtl/imem_fetch_ctrl_fifo2.sv - 2-entry prefetch FIFO with flush taking priority over push/pop
module imem_fetch_ctrl_fifo2
  import imem_fetch_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  entry_t     wr_entry,
  output logic [1:0] count,
  output entry_t     head
);

  entry_t mem [2];
  logic   rd_ptr;
  logic   wr_ptr;
  logic   do_push;
  logic   do_pop;

  // Qualify requests: never pop empty, only push into a full FIFO when the head leaves.
  always_comb begin
    do_pop  = pop && (count != 2'd0);
    do_push = push && ((count != 2'd2) || do_pop);
    head    = mem[rd_ptr];
  end

  // Storage needs no reset; count decides what is visible.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  // Pointers and occupancy; a flush simply empties the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// rtl/imem_fetch_ctrl.sv - fetch PC, ROM addressing, run/idle FSM and prefetch buffer control
module imem_fetch_ctrl
  import imem_fetch_ctrl_pkg::*;
#(
  parameter int          ADDR_BITS = 4,
  parameter logic [31:0] RESET_PC  = 32'h00000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fetch_en,
  output logic                busy,
  imem_fetch_ctrl_if.master   bus
);

  state_t      state;
  state_t      state_nxt;
  logic [31:0] fetch_pc;
  logic [1:0]  count;
  entry_t      head;
  entry_t      new_entry;
  logic        head_valid;
  logic        pop;
  logic        push;
  logic        flush;

  // Run/idle state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next state follows fetch_en; buffer contents survive a drop to idle.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (fetch_en)  state_nxt = S_RUN;
      S_RUN:   if (!fetch_en) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Handshake decode: a redirect cancels both the pop and the push of its cycle.
  always_comb begin
    head_valid = (count != 2'd0);
    busy       = (state == S_RUN);
    flush      = bus.redirect_valid && (state == S_RUN);
    pop        = head_valid && bus.instr_ready && !bus.redirect_valid;
    push       = (state == S_RUN) && fetch_en && !bus.redirect_valid
                 && ((count != 2'd2) || pop);
    new_entry  = '{pc: fetch_pc, insn: bus.rom_data};
  end

  // Fetch PC: redirect wins, otherwise step one word per accepted push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
    end else if (bus.redirect_valid) begin
      fetch_pc <= align_pc(bus.redirect_pc);
    end else if (push) begin
      fetch_pc <= fetch_pc + 32'd4;
    end
  end

  imem_fetch_ctrl_fifo2 u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .flush    (flush),
    .wr_entry (new_entry),
    .count    (count),
    .head     (head)
  );

  assign bus.rom_addr    = fetch_pc[ADDR_BITS+1:2];
  assign bus.instr_valid = head_valid;
  assign bus.instr       = head_valid ? head.insn : NOP_INSN;
  assign bus.instr_pc    = head_valid ? head.pc : 32'd0;

endmodule
